// File: rtl/tl45_register_read.sv
// tl45 register-read stage: 16x32 register file, operand forwarding, load-use bubbles.
// Optional same-cycle writeback bypass is enabled by defining TL45_RR_WB_BYPASS_EN.
module tl45_register_read #(
  parameter int unsigned LOAD_BUBBLES = 2,
  parameter logic [4:0]  NOP_OPCODE   = 5'h00
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  output logic        o_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_flush,
  input  logic        i_valid,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [3:0]  i_sr1,
  input  logic [3:0]  i_sr2,
  input  logic [31:0] i_pc,
  input  logic        i_fwd_valid,
  input  logic        i_fwd_is_load,
  input  logic [3:0]  i_fwd_dr,
  input  logic [31:0] i_fwd_val,
  input  logic        i_wb_en,
  input  logic [3:0]  i_wb_dr,
  input  logic [31:0] i_wb_val,
  output logic        o_valid,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [3:0]  o_sr1,
  output logic [3:0]  o_sr2,
  output logic [31:0] o_sr1_val,
  output logic [31:0] o_sr2_val,
  output logic [31:0] o_pc
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  // Bubbles still owed after the one issued on the hazard edge.
  localparam logic [1:0] BubbleInit = 2'(LOAD_BUBBLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rf_q [16];

  logic        valid_q;
  logic [4:0]  opcode_q;
  logic [3:0]  dr_q, sr1_q, sr2_q;
  logic [31:0] sr1_val_q, sr2_val_q, pc_q;

  logic        haz;
  logic        load_bubble, load_instr;
  logic [3:0]  src [2];
  logic [31:0] src_val [2];

  assign src[0] = i_sr1;
  assign src[1] = i_sr2;

  // Lowest priority first; later matches overwrite earlier ones.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      src_val[k] = rf_q[src[k]];
`ifdef TL45_RR_WB_BYPASS_EN
      if (i_wb_en && i_wb_dr == src[k]) src_val[k] = i_wb_val;
`endif
      if (i_fwd_valid && !i_fwd_is_load && i_fwd_dr == src[k]) src_val[k] = i_fwd_val;
      if (src[k] == 4'd0) src_val[k] = '0;
    end
  end

  assign haz = i_valid && i_fwd_valid && i_fwd_is_load && i_fwd_dr != 4'd0 &&
               (i_fwd_dr == i_sr1 || i_fwd_dr == i_sr2);

  assign o_pipe_stall = i_pipe_stall | haz | (state_q == StBubble);
  assign o_pipe_flush = i_pipe_flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_bubble = 1'b0;
    load_instr  = 1'b0;
    if (i_pipe_flush) begin
      load_bubble = 1'b1;
      state_d     = StRun;
      cnt_d       = 2'd0;
    end else if (!i_pipe_stall) begin
      unique case (state_q)
        StRun: begin
          if (haz) begin
            load_bubble = 1'b1;
            if (BubbleInit != 2'd0) begin
              state_d = StBubble;
              cnt_d   = BubbleInit;
            end
          end else if (i_valid) begin
            load_instr = 1'b1;
          end else begin
            load_bubble = 1'b1;
          end
        end
        StBubble: begin
          load_bubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writeback lands regardless of stall or flush.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < 16; r++) rf_q[r] <= '0;
    end else if (i_wb_en && i_wb_dr != 4'd0) begin
      rf_q[i_wb_dr] <= i_wb_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q   <= 1'b0;
      opcode_q  <= NOP_OPCODE;
      dr_q      <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      sr1_val_q <= '0;
      sr2_val_q <= '0;
      pc_q      <= '0;
    end else if (load_bubble) begin
      valid_q   <= 1'b0;
      opcode_q  <= NOP_OPCODE;
      dr_q      <= '0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      sr1_val_q <= '0;
      sr2_val_q <= '0;
      pc_q      <= '0;
    end else if (load_instr) begin
      valid_q   <= 1'b1;
      opcode_q  <= i_opcode;
      dr_q      <= i_dr;
      sr1_q     <= i_sr1;
      sr2_q     <= i_sr2;
      sr1_val_q <= src_val[0];
      sr2_val_q <= src_val[1];
      pc_q      <= i_pc;
    end
  end

  assign o_valid   = valid_q;
  assign o_opcode  = opcode_q;
  assign o_dr      = dr_q;
  assign o_sr1     = sr1_q;
  assign o_sr2     = sr2_q;
  assign o_sr1_val = sr1_val_q;
  assign o_sr2_val = sr2_val_q;
  assign o_pc      = pc_q;

endmodule

// File: tb/tb_tl45_register_read.sv
// Directed bench for tl45_register_read: a sequential vector table plus stall, flush and
// reset-mid-bubble sequences. Expected bypass behaviour follows TL45_RR_WB_BYPASS_EN.
module tb_tl45_register_read;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_stall, o_pipe_stall, i_pipe_flush, o_pipe_flush;
  logic        i_valid;
  logic [4:0]  i_opcode;
  logic [3:0]  i_dr, i_sr1, i_sr2;
  logic [31:0] i_pc;
  logic        i_fwd_valid, i_fwd_is_load;
  logic [3:0]  i_fwd_dr;
  logic [31:0] i_fwd_val;
  logic        i_wb_en;
  logic [3:0]  i_wb_dr;
  logic [31:0] i_wb_val;
  logic        o_valid;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr, o_sr1, o_sr2;
  logic [31:0] o_sr1_val, o_sr2_val, o_pc;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  tl45_register_read dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pipe_stall  (i_pipe_stall),
    .o_pipe_stall  (o_pipe_stall),
    .i_pipe_flush  (i_pipe_flush),
    .o_pipe_flush  (o_pipe_flush),
    .i_valid       (i_valid),
    .i_opcode      (i_opcode),
    .i_dr          (i_dr),
    .i_sr1         (i_sr1),
    .i_sr2         (i_sr2),
    .i_pc          (i_pc),
    .i_fwd_valid   (i_fwd_valid),
    .i_fwd_is_load (i_fwd_is_load),
    .i_fwd_dr      (i_fwd_dr),
    .i_fwd_val     (i_fwd_val),
    .i_wb_en       (i_wb_en),
    .i_wb_dr       (i_wb_dr),
    .i_wb_val      (i_wb_val),
    .o_valid       (o_valid),
    .o_opcode      (o_opcode),
    .o_dr          (o_dr),
    .o_sr1         (o_sr1),
    .o_sr2         (o_sr2),
    .o_sr1_val     (o_sr1_val),
    .o_sr2_val     (o_sr2_val),
    .o_pc          (o_pc)
  );

  typedef struct {
    logic        vld;
    logic [4:0]  op;
    logic [3:0]  dr, s1, s2;
    logic [31:0] pc;
    logic        fv, fld;
    logic [3:0]  fdr;
    logic [31:0] fval;
    logic        we;
    logic [3:0]  wdr;
    logic [31:0] wval;
    logic        stl, fsh;
    logic        x_stall, x_vld;
    logic [4:0]  x_op;
    logic [3:0]  x_dr;
    logic [31:0] x_s1v, x_s2v, x_pc;
  } vec_t;

  localparam int NumVec = 18;
  localparam logic [4:0] Nop = 5'h00;
`ifdef TL45_RR_WB_BYPASS_EN
  localparam logic [31:0] BypR10 = 32'h55;
`else
  localparam logic [31:0] BypR10 = 32'h0;
`endif

  vec_t tbl [NumVec];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
    i_valid = 1'b0; i_opcode = '0; i_dr = '0; i_sr1 = '0; i_sr2 = '0; i_pc = '0;
    i_fwd_valid = 1'b0; i_fwd_is_load = 1'b0; i_fwd_dr = '0; i_fwd_val = '0;
    i_wb_en = 1'b0; i_wb_dr = '0; i_wb_val = '0;
  endtask

  task automatic instr(input logic [4:0] op, input logic [3:0] dr, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [31:0] pc);
    i_valid = 1'b1; i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2; i_pc = pc;
  endtask

  task automatic apply(input vec_t v);
    i_valid = v.vld; i_opcode = v.op; i_dr = v.dr; i_sr1 = v.s1; i_sr2 = v.s2; i_pc = v.pc;
    i_fwd_valid = v.fv; i_fwd_is_load = v.fld; i_fwd_dr = v.fdr; i_fwd_val = v.fval;
    i_wb_en = v.we; i_wb_dr = v.wdr; i_wb_val = v.wval;
    i_pipe_stall = v.stl; i_pipe_flush = v.fsh;
  endtask

  initial begin
    // vld op dr s1 s2 pc | fv fld fdr fval | we wdr wval | stl fsh | x_stall x_vld x_op x_dr s1v s2v pc
    tbl[0]  = '{1'b0, Nop, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b1, 4'd3, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 5'h01, 4'd1, 4'd3, 4'd0, 32'h100, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 4'd1, 32'h1234, 32'h0, 32'h100};
    tbl[2]  = '{1'b0, Nop, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b1, 4'd5, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b1, 5'h01, 4'd2, 4'd3, 4'd5, 32'h104, 1'b1, 1'b0, 4'd5, 32'hDEAD,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h01, 4'd2, 32'h1234, 32'hDEAD, 32'h104};
    // Load in ALU stage targeting r0: no hazard, r0 still reads zero.
    tbl[4]  = '{1'b1, 5'h02, 4'd6, 4'd0, 4'd5, 32'h108, 1'b1, 1'b1, 4'd0, 32'hBEEF,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h02, 4'd6, 32'h0, 32'h1, 32'h108};
    tbl[5]  = '{1'b0, Nop, 4'd0, 4'd0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd5, 32'hDEAD,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    // Load-use on sr1: two bubbles, then the written-back file value.
    tbl[6]  = '{1'b1, 5'h03, 4'd8, 4'd4, 4'd0, 32'h10C, 1'b1, 1'b1, 4'd4, 32'hBAD,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 5'h03, 4'd8, 4'd4, 4'd0, 32'h10C, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b1, 4'd4, 32'h4444, 1'b0, 1'b0, 1'b1, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 5'h03, 4'd8, 4'd4, 4'd0, 32'h10C, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h03, 4'd8, 32'h4444, 32'h0, 32'h10C};
    // ALU forward beats same-cycle writeback.
    tbl[9]  = '{1'b1, 5'h04, 4'd9, 4'd9, 4'd9, 32'h110, 1'b1, 1'b0, 4'd9, 32'h99,
                1'b1, 4'd9, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 5'h04, 4'd9, 32'h99, 32'h99, 32'h110};
    tbl[10] = '{1'b1, 5'h05, 4'd1, 4'd10, 4'd3, 32'h114, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b1, 4'd10, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 5'h05, 4'd1, BypR10, 32'h1234, 32'h114};
    tbl[11] = '{1'b1, 5'h06, 4'd2, 4'd10, 4'd4, 32'h118, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h06, 4'd2, 32'h55, 32'h4444, 32'h118};
    // Load-use on sr2.
    tbl[12] = '{1'b1, 5'h07, 4'd3, 4'd1, 4'd6, 32'h11C, 1'b1, 1'b1, 4'd6, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 5'h07, 4'd3, 4'd1, 4'd6, 32'h11C, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b1, 4'd6, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[14] = '{1'b1, 5'h07, 4'd3, 4'd1, 4'd6, 32'h11C, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h07, 4'd3, 32'h0, 32'h66, 32'h11C};
    tbl[15] = '{1'b1, 5'h08, 4'd1, 4'd3, 4'd3, 32'h120, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    // Flush overrides a concurrent hazard: no BUBBLE state afterwards.
    tbl[16] = '{1'b1, 5'h08, 4'd1, 4'd4, 4'd0, 32'h124, 1'b1, 1'b1, 4'd4, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, Nop, 4'd0, 32'h0, 32'h0, 32'h0};
    tbl[17] = '{1'b1, 5'h08, 4'd1, 4'd4, 4'd0, 32'h124, 1'b0, 1'b0, 4'd0, 32'h0,
                1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h08, 4'd1, 32'h4444, 32'h0, 32'h124};

    idle_inputs();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_valid", {31'b0, o_valid}, 32'h0);
    chk("reset_opcode", {27'b0, o_opcode}, {27'b0, Nop});
    chk("reset_pc", o_pc, 32'h0);
    chk("reset_stall", {31'b0, o_pipe_stall}, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge i_clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_pipe_stall", i), {31'b0, o_pipe_stall}, {31'b0, tbl[i].x_stall});
      chk($sformatf("v%0d_pipe_flush", i), {31'b0, o_pipe_flush}, {31'b0, tbl[i].fsh});
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].x_vld});
      chk($sformatf("v%0d_opcode", i), {27'b0, o_opcode}, {27'b0, tbl[i].x_op});
      chk($sformatf("v%0d_dr", i), {28'b0, o_dr}, {28'b0, tbl[i].x_dr});
      if (tbl[i].x_vld) begin
        chk($sformatf("v%0d_sr1", i), {28'b0, o_sr1}, {28'b0, tbl[i].s1});
        chk($sformatf("v%0d_sr2", i), {28'b0, o_sr2}, {28'b0, tbl[i].s2});
        chk($sformatf("v%0d_sr1_val", i), o_sr1_val, tbl[i].x_s1v);
        chk($sformatf("v%0d_sr2_val", i), o_sr2_val, tbl[i].x_s2v);
        chk($sformatf("v%0d_pc", i), o_pc, tbl[i].x_pc);
      end
    end

    // Downstream stall holds the buffer; writeback to r7 still lands.
    @(negedge i_clk);
    idle_inputs();
    instr(5'h09, 4'd2, 4'd3, 4'd0, 32'h200);
    @(posedge i_clk);
    #1;
    chk("stall_pre_pc", o_pc, 32'h200);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      idle_inputs();
      instr(5'h0A, 4'd4, 4'd5, 4'd5, 32'h300);
      i_pipe_stall = 1'b1;
      if (c == 0) begin
        i_wb_en = 1'b1; i_wb_dr = 4'd7; i_wb_val = 32'h77;
      end
      #1;
      chk($sformatf("stall%0d_pipe_stall", c), {31'b0, o_pipe_stall}, 32'h1);
      @(posedge i_clk);
      #1;
      chk($sformatf("stall%0d_pc", c), o_pc, 32'h200);
      chk($sformatf("stall%0d_opcode", c), {27'b0, o_opcode}, 32'h09);
      chk($sformatf("stall%0d_sr1_val", c), o_sr1_val, 32'h1234);
    end
    @(negedge i_clk);
    idle_inputs();
    instr(5'h0A, 4'd4, 4'd7, 4'd0, 32'h304);
    @(posedge i_clk);
    #1;
    chk("stall_rel_sr1_val", o_sr1_val, 32'h77);
    chk("stall_rel_pc", o_pc, 32'h304);

    // Flush arriving in BUBBLE with one bubble still owed.
    @(negedge i_clk);
    idle_inputs();
    instr(5'h0B, 4'd1, 4'd4, 4'd0, 32'h400);
    i_fwd_valid = 1'b1; i_fwd_is_load = 1'b1; i_fwd_dr = 4'd4;
    @(posedge i_clk);
    @(negedge i_clk);
    idle_inputs();
    instr(5'h0B, 4'd1, 4'd3, 4'd0, 32'h400);
    i_pipe_flush = 1'b1;
    #1;
    chk("flush_pipe_flush", {31'b0, o_pipe_flush}, 32'h1);
    chk("flush_in_bubble_stall", {31'b0, o_pipe_stall}, 32'h1);
    @(posedge i_clk);
    #1;
    chk("flush_valid", {31'b0, o_valid}, 32'h0);
    @(negedge i_clk);
    i_pipe_flush = 1'b0;
    #1;
    chk("flush_after_stall", {31'b0, o_pipe_stall}, 32'h0);
    @(posedge i_clk);
    #1;
    chk("flush_after_valid", {31'b0, o_valid}, 32'h1);
    chk("flush_after_pc", o_pc, 32'h400);

    // Asynchronous reset while in BUBBLE.
    @(negedge i_clk);
    idle_inputs();
    instr(5'h0C, 4'd2, 4'd4, 4'd0, 32'h500);
    i_fwd_valid = 1'b1; i_fwd_is_load = 1'b1; i_fwd_dr = 4'd4;
    @(posedge i_clk);
    @(negedge i_clk);
    i_fwd_valid = 1'b0; i_fwd_is_load = 1'b0; i_fwd_dr = 4'd0;
    #1;
    chk("rst_mid_pre_stall", {31'b0, o_pipe_stall}, 32'h1);
    i_reset = 1'b0;
    #1;
    chk("rst_mid_stall", {31'b0, o_pipe_stall}, 32'h0);
    chk("rst_mid_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_mid_pc", o_pc, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    idle_inputs();
    instr(5'h0C, 4'd2, 4'd3, 4'd0, 32'h504);
    @(posedge i_clk);
    #1;
    chk("rst_mid_after_valid", {31'b0, o_valid}, 32'h1);
    chk("rst_mid_rf_cleared", o_sr1_val, 32'h0);
    chk("rst_mid_after_pc", o_pc, 32'h504);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl45_register_read.md
Name: tl45_register_read

Overview:
- Register-read stage of the tl45 pipeline, directly upstream of the ALU stage.
- Holds the 16x32 architectural register file and resolves source operands from the file, the ALU-output forward path, or zero for r0.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU input buffer: opcode, dr, sr1, sr2, sr1_val, sr2_val, pc.

Parameters:
- LOAD_BUBBLES, 2: number of bubble cycles inserted on a load-use hazard (1..3).
- NOP_OPCODE, 5'h00: opcode emitted for a bubble.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_pipe_stall  in  1  downstream stall; hold output buffer.
- o_pipe_stall  out  1  stall to decode stage.
- i_pipe_flush  in  1  flush request.
- o_pipe_flush  out  1  forwarded flush.
- i_valid  in  1  decode buffer holds a real instruction.
- i_opcode  in  5  decoded opcode.
- i_dr, i_sr1, i_sr2  in  4 each  destination and source register indices.
- i_pc  in  32  instruction PC.
- i_fwd_valid  in  1  ALU output buffer holds a register-writing result.
- i_fwd_is_load  in  1  that ALU-stage instruction is a load (value not yet known).
- i_fwd_dr  in  4  ALU-stage destination.
- i_fwd_val  in  32  ALU-stage result.
- i_wb_en  in  1  writeback write enable.
- i_wb_dr  in  4  writeback destination.
- i_wb_val  in  32  writeback data.
- o_valid  out  1  output buffer holds a real instruction.
- o_opcode  out  5  buffered opcode.
- o_dr, o_sr1, o_sr2  out  4 each  buffered register indices.
- o_sr1_val, o_sr2_val  out  32 each  resolved operands.
- o_pc  out  32  buffered PC.

Behaviour:
- Reset (i_reset=0, async):
  - All output-buffer registers and all 16 register-file entries cleared to 0.
  - o_opcode = NOP_OPCODE, o_valid = 0.
  - FSM to RUN, bubble counter = 0.
- Register file:
  - Written on posedge when i_wb_en && i_wb_dr != 0, independent of stall/flush.
  - Writes to r0 are ignored; r0 always reads 0.
- Operand resolution, per source s (sr1, sr2), in priority order:
  1. s == 0 gives 0.
  2. i_fwd_valid && !i_fwd_is_load && i_fwd_dr == s gives i_fwd_val.
  3. WB bypass (only when the optional feature is compiled in).
  4. Register-file read.
- Hazard (combinational):
  - haz = i_valid && i_fwd_valid && i_fwd_is_load && i_fwd_dr != 0 && (i_fwd_dr == i_sr1 || i_fwd_dr == i_sr2).
- FSM states:
  - RUN: if haz and no stall/flush, load a bubble (o_valid=0, o_opcode=NOP_OPCODE, o_dr=0) and go to BUBBLE with cnt = LOAD_BUBBLES-1. If cnt would be 0, stay RUN, since one bubble is already issued.
  - BUBBLE: each unstalled cycle, load a bubble and decrement cnt. At cnt == 0 return to RUN. Operands are then re-read fresh from the file.
- o_pipe_stall = i_pipe_stall | haz | (state == BUBBLE).
- i_pipe_stall=1: output buffer and FSM/counter hold. Register-file writes still occur.
- Flush:
  - o_pipe_flush = i_pipe_flush, combinational.
  - On flush, the next edge loads a bubble, FSM goes to RUN, cnt = 0.
  - Flush has priority over stall and hazard.
- Normal case (RUN, no haz/stall/flush): buffer captures the inputs and resolved operands at the next edge. Latency is 1 cycle.
- i_valid=0 with no stall: the buffer loads a bubble.
- Reset asserted mid-bubble: immediate return to RUN with a cleared buffer.

Optional Feature:
- Macro: TL45_RR_WB_BYPASS_EN.
- Defined: priority 3 of operand resolution is i_wb_en && i_wb_dr == s, which gives i_wb_val (same-cycle write-through).
- Undefined: no bypass. A same-cycle writeback is seen only via the file on the following cycle, so the decode stage keeps at least one slot of separation.

Test Plan:
- Reset, then write r3=0x1234 via WB. Next cycle issue ADD sr1=3 sr2=0 pc=0x100 -> after 1 cycle: o_valid=1, o_sr1_val=0x1234, o_sr2_val=0, o_pc=0x100.
- i_fwd_valid=1, i_fwd_dr=5, i_fwd_val=0xDEAD, file r5=0x1 -> o_sr2_val=0xDEAD for sr2=5.
- Load-use: i_fwd_is_load=1, i_fwd_dr=4, incoming sr1=4, LOAD_BUBBLES=2 -> o_pipe_stall high for 2 cycles, 2 bubbles (o_valid=0), then an instruction carrying the file value of r4.
- i_pipe_stall=1 for 3 cycles with a new input present -> outputs unchanged; WB write to r7 still lands (readable after release).
- i_pipe_flush=1 during BUBBLE with cnt=1 -> o_pipe_flush=1 same cycle, next cycle o_valid=0, FSM in RUN, o_pipe_stall=0.
- With TL45_RR_WB_BYPASS_EN: i_wb_en=1, dr=9, val=0x55 and same-cycle sr1=9 -> o_sr1_val=0x55. Without the macro -> old file value.
